// File: rtl/cordic_pkg.sv
// cordic_pkg: pipeline word, constants and iteration helpers for cordic (gain() only with CORDIC_GAIN_COMP_EN)
package cordic_pkg;
  localparam int N_ITER = 12;
  localparam int PI = 25736;
  localparam int HALF_PI = 12868;
  localparam int K = 9949;
  localparam logic signed [15:0] ATAN [N_ITER] = '{
    16'sd6434, 16'sd3798, 16'sd2007, 16'sd1019, 16'sd511, 16'sd256,
    16'sd128, 16'sd64, 16'sd32, 16'sd16, 16'sd8, 16'sd4
  };
  typedef struct packed {
    logic               mode;
    logic signed [17:0] x;
    logic signed [17:0] y;
    logic signed [15:0] z;
  } cordic_t;
  function automatic cordic_t iter(cordic_t s, int i);
    logic signed [17:0] xs, ys;
    logic dp;
    dp = s.mode ? s.y[17] : ~s.z[15];
    xs = $signed(s.x) >>> i;
    ys = $signed(s.y) >>> i;
    iter = s;
    iter.x = dp ? s.x - ys : s.x + ys;
    iter.y = dp ? s.y + xs : s.y - xs;
    iter.z = dp ? s.z - ATAN[4'(i)] : s.z + ATAN[4'(i)];
  endfunction
  function automatic logic signed [15:0] sat(logic signed [17:0] v);
    return v > 18'sd32767 ? 16'h7fff : v < -18'sd32768 ? 16'h8000 : v[15:0];
  endfunction
`ifdef CORDIC_GAIN_COMP_EN
  // 9949 = 2^13 + 2^10 + 2^9 + 2^7 + 2^6 + 2^4 + 2^3 + 2^2 + 2^0
  function automatic logic signed [17:0] gain(logic signed [17:0] v);
    logic signed [31:0] w;
    w = 32'(v);
    return 18'(((w <<< 13) + (w <<< 10) + (w <<< 9) + (w <<< 7) + (w <<< 6) +
                (w <<< 4) + (w <<< 3) + (w <<< 2) + w) >>> 14);
  endfunction
`endif
endpackage

// File: rtl/cordic_stage.sv
// cordic_stage: two registered CORDIC micro-rotations, iterations I0 and I0+1
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int I0 = 0
) (
  input  logic    clk,
  input  logic    reset,
  input  cordic_t d,
  output cordic_t q
);
  always_ff @(posedge clk) q <= reset ? '0 : iter(iter(d, I0), I0 + 1);
endmodule

// File: rtl/cordic.sv
// cordic: 12-iteration pipelined rotation/vectoring CORDIC, 8-cycle latency; CORDIC_GAIN_COMP_EN gives unit gain
module cordic
  import cordic_pkg::*;
(
  input  logic               mode,
  input  logic signed [15:0] x,
  input  logic signed [15:0] y,
  input  logic signed [15:0] z,
  input  logic               clk,
  input  logic               reset,
  output logic signed [15:0] res1,
  output logic signed [15:0] res2
);
  cordic_t pre, r0;
  cordic_t s [7];
  logic flip;
  logic signed [17:0] xf, yf;
  // fold inputs into the right half-plane / +-pi/2 so 12 iterations converge
  always_comb begin
    flip = mode ? x[15] : (int'(z) > HALF_PI || int'(z) < -HALF_PI);
    pre.mode = mode;
    pre.x = flip ? -18'(x) : 18'(x);
    pre.y = flip ? -18'(y) : 18'(y);
    pre.z = mode ? (flip ? (y[15] ? -16'(PI) : 16'(PI)) : '0)
                 : (flip ? (z[15] ? z + 16'(PI) : z - 16'(PI)) : z);
  end
  always_ff @(posedge clk) r0 <= reset ? '0 : pre;
  assign s[0] = r0;
  for (genvar g = 0; g < 6; g++) begin : g_stage
    cordic_stage #(.I0(2 * g)) u_stage (.clk(clk), .reset(reset), .d(s[g]), .q(s[g + 1]));
  end
`ifdef CORDIC_GAIN_COMP_EN
  assign xf = gain(s[6].x);
  assign yf = gain(s[6].y);
`else
  assign xf = s[6].x;
  assign yf = s[6].y;
`endif
  always_ff @(posedge clk) begin
    res1 <= reset ? '0 : sat(xf);
    res2 <= reset ? '0 : s[6].mode ? s[6].z : sat(yf);
  end
endmodule

// File: tb/tb_cordic.sv
// tb_cordic: randomized scoreboard bench for cordic against a real-arithmetic reference model
module tb_cordic;
  logic clk = 0, reset = 1, mode = 0;
  logic signed [15:0] x = 0, y = 0, z = 0;
  logic signed [15:0] res1, res2;
  int cyc = 0, checks = 0, errors = 0;
  real g, tc;
  typedef struct {
    int  due;
    real e1, e2, t1, t2;
    bit  ang;
  } exp_t;
  exp_t q [$];

  cordic dut (.mode(mode), .x(x), .y(y), .z(z), .clk(clk), .reset(reset), .res1(res1), .res2(res2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic real clampr(real v);
    return v > 32767.0 ? 32767.0 : v < -32768.0 ? -32768.0 : v;
  endfunction

  task automatic push(int due, real e1, real e2, real t1, real t2, bit ang);
    exp_t e;
    e.due = due; e.e1 = e1; e.e2 = e2; e.t1 = t1; e.t2 = t2; e.ang = ang;
    q.push_back(e);
  endtask

  // outputs must read 0 through the reset cycles and until the first post-reset result
  task automatic do_reset(int n);
    reset = 1;
    q.delete();
    for (int k = 1; k <= n + 7; k++) push(cyc + k, 0.0, 0.0, 0.0, 0.0, 0);
    repeat (n) @(negedge clk);
    reset = 0;
  endtask

  task automatic drive(bit m, int xi, int yi, int zi, real t1 = -1.0, real t2 = -1.0);
    real a, r, e1, e2;
    mode = m; x = 16'(xi); y = 16'(yi); z = 16'(zi);
    r = $sqrt(real'(xi) * real'(xi) + real'(yi) * real'(yi));
    if (!m) begin
      a = real'(zi) / 8192.0;
      e1 = g * (real'(xi) * $cos(a) - real'(yi) * $sin(a));
      e2 = g * (real'(xi) * $sin(a) + real'(yi) * $cos(a));
    end else begin
      e1 = g * r;
      e2 = $atan2(real'(yi), real'(xi)) * 8192.0;
    end
    if (t1 < 0.0) t1 = 10.0 + 1.0e-3 * g * r;
    if (t2 < 0.0) t2 = m ? 6.0 + 8192.0 * 16.0 / (1.6468 * (r + 1.0)) : t1;
    push(cyc + 8, clampr(e1), m ? e2 : clampr(e2), t1, t2, m);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    real d1, d2;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      d1 = real'(res1) - e.e1;
      d2 = real'(res2) - e.e2;
      if (e.ang && d2 > 25736.0) d2 -= 51472.0;
      if (e.ang && d2 < -25736.0) d2 += 51472.0;
      checks += 2;
      if (d1 > e.t1 || d1 < -e.t1) begin
        errors++;
        $display("FAIL res1 cycle %0d: got %0d expected %0.1f tol %0.1f", cyc, res1, e.e1, e.t1);
      end
      if (d2 > e.t2 || d2 < -e.t2) begin
        errors++;
        $display("FAIL res2 cycle %0d: got %0d expected %0.1f tol %0.1f", cyc, res2, e.e2, e.t2);
      end
    end
  end

  initial begin
    int xi, yi, zi;
    bit m;
    g = 1.0;
    for (int i = 0; i < 12; i++) g = g * $sqrt(1.0 + $pow(2.0, -2.0 * i));
    tc = 16.0;
`ifdef CORDIC_GAIN_COMP_EN
    g = g * 9949.0 / 16384.0;
    tc = 8.0;
`endif
    do_reset(2);
    drive(0, 16384, 0, 0, tc, tc);
    drive(1, 16384, 16384, 12345, tc, 4.0);
    drive(0, 16384, 0, 6434, tc, tc);
    drive(1, -16384, 0, -777, tc, 4.0);
    drive(0, 16384, 0, 12868);
    drive(0, 16384, 0, 12869);
    drive(0, 16384, 0, -12869);
    drive(0, -32768, -32768, -32768);
    drive(0, 32767, 32767, 3000);
    drive(1, -32768, -1, 0);
    drive(1, -32768, 0, 0);
    drive(1, 0, 16384, 0);
    drive(1, 0, -16384, 0);
    for (int k = 0; k < 400; k++) begin
      if (k == 250) do_reset(3);
      m = 1'($urandom_range(0, 1));
      zi = int'($urandom_range(0, 65535)) - 32768;
      do begin
        xi = int'($urandom_range(0, 65535)) - 32768;
        yi = int'($urandom_range(0, 65535)) - 32768;
      end while (m && xi * xi + yi * yi < 4000000);
      drive(m, xi, yi, zi);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
